// File: rtl/div_pkg.sv
// Shared types and constants for the sequential integer divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

    // RISC-V M-extension funct3 codes for the divide group
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    function automatic logic f3_is_signed(input logic [2:0] funct3);
        return (funct3 == F3_DIV) || (funct3 == F3_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only when it is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] partial;

    // rem < divisor on entry, so a successful difference always fits WIDTH bits
    always_comb begin
        partial  = {rem, dvd_msb};
        qbit     = (partial >= {1'b0, divisor});
        rem_next = qbit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/int_div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per cycle.
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | iterating, cnt_q = current quotient bit index from the top
// S_FIX  | apply result signs, load q/r
// S_DONE | ready pulse; may accept the next start directly
module int_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign accept    = start && !cancel && (state_q == S_IDLE || state_q == S_DONE);
    assign last_iter = (cnt_q == LAST_ITER);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            r_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            r_q       <= r_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = (b == '0) ? S_FIX : S_CALC;
                else        state_d = S_IDLE;
            end
            S_CALC: begin
                if (cancel)         state_d = S_IDLE;
                else if (last_iter) state_d = S_FIX;
            end
            S_FIX:   state_d = cancel ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == S_CALC) || (state_q == S_FIX);
        ready = (state_q == S_DONE);
    end

    // The dividend register doubles as the quotient: bits leave at the top
    // and quotient bits enter at the bottom.
    always_comb begin
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        q_d       = q_q;
        r_d       = r_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;

        if (accept) begin
            cnt_d  = '0;
            rem_d  = '0;
            div0_d = (b == '0);
            if (b == '0 || !sign) begin
                dvd_d     = a;
                dvs_d     = b;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
            end else begin
                dvd_d     = a[WIDTH-1] ? -a : a;
                dvs_d     = b[WIDTH-1] ? -b : b;
                neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                neg_rem_d = a[WIDTH-1];
            end
        end else if (state_q == S_CALC && !cancel) begin
            rem_d = rem_next;
            dvd_d = {dvd_q[WIDTH-2:0], qbit};
            cnt_d = last_iter ? '0 : cnt_q + CNT_W'(1);
        end

        // Divide-by-zero skipped CALC, so dvd_q still holds the raw dividend
        if (state_q == S_FIX && !cancel) begin
            if (div0_q) begin
                q_d = '1;
                r_d = dvd_q;
            end else begin
                q_d = neg_quo_q ? -dvd_q : dvd_q;
                r_d = neg_rem_q ? -rem_q : rem_q;
            end
        end
    end

    assign q = q_q;
    assign r = r_q;

endmodule

// File: tb/tb_int_div_seq.sv
// Directed-vector bench for int_div_seq with hand-computed results.
module tb_int_div_seq;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    int_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .start  (start),
        .sign   (sign),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .q      (q),
        .r      (r),
        .busy   (busy),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge; cyc counts edges from that edge inclusive.
    task automatic wait_rdy(input bit noise, output int cyc, output int bc);
        cyc = 1;
        bc  = 0;
        while (!ready && cyc <= 60) begin
            if (busy) bc++;
            if (noise && cyc == 3) begin
                start = 1'b1;
                a     = 32'd5;
                b     = 32'd1;
            end
            if (noise && cyc == 6) start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] ai,
                           input logic [31:0] bi, input logic [31:0] eq,
                           input logic [31:0] er, input int elat, input bit noise);
        int cyc, bc;
        sign  = s;
        a     = ai;
        b     = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_rdy(noise, cyc, bc);
        chk({tag, " latency"}, cyc, elat);
        chk({tag, " busy cycles"}, bc, elat - 1);
        chk({tag, " q"}, q, eq);
        chk({tag, " r"}, r, er);
        @(posedge clk);
        #1;
        chk({tag, " ready single pulse"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, bc, seen;
        clrn   = 1'b0;
        start  = 1'b0;
        sign   = 1'b0;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset q", q, 32'd0);
        chk("reset r", r, 32'd0);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        run_div("divu 100/7", f3_is_signed(F3_DIVU), 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0);
        run_div("div -100/7", f3_is_signed(F3_DIV), 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 34, 1'b0);
        run_div("div 100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 34, 1'b0);
        run_div("div -100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 34, 1'b0);
        run_div("divu by 0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 2, 1'b0);
        run_div("div by 0", 1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 2, 1'b0);
        run_div("div -3 by 0", 1'b1, 32'hFFFFFFFD, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 2, 1'b0);
        run_div("div overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34, 1'b0);
        run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 34, 1'b0);

        // cancel beats start in IDLE
        sign   = 1'b0;
        a      = 32'd9;
        b      = 32'd2;
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        chk("cancel+start idle busy", {31'd0, busy}, 32'd0);

        // cancel at CALC iteration 10
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy before cancel", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready) seen++;
            @(posedge clk);
            #1;
        end
        chk("cancel no ready", seen, 0);
        chk("cancel q hold", q, 32'hFFFFFFFF);
        chk("cancel r hold", r, 32'd0);

        // start during CALC must be ignored
        run_div("divu 1000/3 noisy start", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 34, 1'b1);

        // async reset mid-operation
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("busy before reset", {31'd0, busy}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("midreset q", q, 32'd0);
        chk("midreset r", r, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset ready", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #3;
        clrn = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back: start held through DONE
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd1000;
        b = 32'd3;
        wait_rdy(1'b0, cyc, bc);
        chk("b2b first latency", cyc, 34);
        chk("b2b first q", q, 32'd14);
        chk("b2b first r", r, 32'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b no idle busy", {31'd0, busy}, 32'd1);
        chk("b2b ready dropped", {31'd0, ready}, 32'd0);
        wait_rdy(1'b0, cyc, bc);
        chk("b2b pulse spacing", cyc, 34);
        chk("b2b second q", q, 32'd333);
        chk("b2b second r", r, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
